// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared FSM states, forward-select encodings and the register-match helper
package hazard_ctrl_pkg;
   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_E  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;
   localparam logic [1:0] FWD_W  = 2'b11;
   function automatic logic reg_hit(input logic en, input logic [4:0] rs, input logic we, input logic [4:0] rd);
      return en && we && (rs == rd) && (rs != 5'd0);
   endfunction
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// hazard_ctrl_fwd_sel: priority E > M > W operand forward select plus load-use detect for one source register
module hazard_ctrl_fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  logic       en,
   input  logic [4:0] rs,
   input  logic       we_e,
   input  logic [4:0] rd_e,
   input  logic       ld_e,
   input  logic       we_m,
   input  logic [4:0] rd_m,
   input  logic       ld_m,
   input  logic       we_w,
   input  logic [4:0] rd_w,
   output logic [1:0] sel,
   output logic       lu
);
   logic hit_e, hit_m, hit_w;
   assign hit_e = reg_hit(en, rs, we_e, rd_e);
   assign hit_m = reg_hit(en, rs, we_m, rd_m);
   assign hit_w = reg_hit(en, rs, we_w, rd_w);
   // a load hit forwards nothing: its data only exists once the load reaches W
   assign sel = hit_e ? (ld_e ? FWD_RF : FWD_E) :
                hit_m ? (ld_m ? FWD_RF : FWD_M) :
                hit_w ? FWD_W : FWD_RF;
   assign lu = (hit_e & ld_e) | (~hit_e & hit_m & ld_m);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush/forward control with memory-wait FSM, timeout halt and perf counters
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             rs1ReadEnable,
   input  logic [4:0]       rs1ReadAddr,
   input  logic             rs2ReadEnable,
   input  logic [4:0]       rs2ReadAddr,
   input  logic             rdWriteEnableE,
   input  logic [4:0]       rdWriteAddrE,
   input  logic             RamReadEnableE,
   input  logic             rdWriteEnableM,
   input  logic [4:0]       rdWriteAddrM,
   input  logic             RamReadEnableM,
   input  logic             rdWriteEnableW,
   input  logic [4:0]       rdWriteAddrW,
   input  logic             redirectE,
   input  logic             memReqM,
   input  logic             memAckM,
   output logic             stallPC,
   output logic             stallF,
   output logic             flushF,
   output logic             stallD,
   output logic             flushD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushM,
   output logic [1:0]       fwdRs1Sel,
   output logic [1:0]       fwdRs2Sel,
   output logic             halted,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   state_t state;
   logic [WW-1:0] wcnt, wnext;
   logic [1:0] sel1, sel2;
   logic lu1, lu2, mem_wait, run, hlt, wt, red, lua;
   hazard_ctrl_fwd_sel u_rs1 (
      .en(rs1ReadEnable), .rs(rs1ReadAddr),
      .we_e(rdWriteEnableE), .rd_e(rdWriteAddrE), .ld_e(RamReadEnableE),
      .we_m(rdWriteEnableM), .rd_m(rdWriteAddrM), .ld_m(RamReadEnableM),
      .we_w(rdWriteEnableW), .rd_w(rdWriteAddrW),
      .sel(sel1), .lu(lu1)
   );
   hazard_ctrl_fwd_sel u_rs2 (
      .en(rs2ReadEnable), .rs(rs2ReadAddr),
      .we_e(rdWriteEnableE), .rd_e(rdWriteAddrE), .ld_e(RamReadEnableE),
      .we_m(rdWriteEnableM), .rd_m(rdWriteAddrM), .ld_m(RamReadEnableM),
      .we_w(rdWriteEnableW), .rd_w(rdWriteAddrW),
      .sel(sel2), .lu(lu2)
   );
   assign mem_wait = memReqM & ~memAckM;
   assign run = rst & (state != HALT);
   assign hlt = rst & (state == HALT);
   assign wt  = run & mem_wait;
   // redirect and load-use wait out a memory stall; E is held so they are seen again afterwards
   assign red = run & ~mem_wait & redirectE;
   assign lua = run & ~mem_wait & ~redirectE & (lu1 | lu2);
   assign stallPC = hlt | wt | lua;
   assign stallF  = hlt | wt | lua;
   assign flushF  = red;
   assign stallD  = hlt | wt;
   assign flushD  = red | lua;
   assign stallE  = hlt | wt;
   assign stallM  = hlt;
   assign flushM  = wt;
   assign fwdRs1Sel = rst ? sel1 : FWD_RF;
   assign fwdRs2Sel = rst ? sel2 : FWD_RF;
   assign halted = state == HALT;
   assign wnext = wcnt + WW'(1);
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= RUN;
         wcnt     <= '0;
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (stallPC) stallCnt <= stallCnt + CNT_W'(1);
         if (flushF) flushCnt <= flushCnt + CNT_W'(1);
         if (state != HALT) begin
            wcnt  <= mem_wait ? wnext : '0;
            state <= !mem_wait ? RUN : (wnext == WW'(MEM_TIMEOUT)) ? HALT : MEM_WAIT;
         end
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors push hand-computed expectations; a negedge monitor pops and compares
module tb_hazard_ctrl;
   typedef struct packed {
      logic [7:0]  ctl;
      logic [1:0]  f1;
      logic [1:0]  f2;
      logic        h;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;
   // ctl = {stallPC, stallF, flushF, stallD, flushD, stallE, stallM, flushM}
   localparam logic [7:0] C_NO = 8'h00, C_LU = 8'hC8, C_RD = 8'h28, C_MW = 8'hD5, C_HT = 8'hD6;
   logic clk = 0, rst = 0;
   logic rs1ReadEnable, rs2ReadEnable, rdWriteEnableE, RamReadEnableE, rdWriteEnableM, RamReadEnableM;
   logic rdWriteEnableW, redirectE, memReqM, memAckM;
   logic [4:0] rs1ReadAddr, rs2ReadAddr, rdWriteAddrE, rdWriteAddrM, rdWriteAddrW;
   logic stallPC, stallF, flushF, stallD, flushD, stallE, stallM, flushM, halted;
   logic [1:0] fwdRs1Sel, fwdRs2Sel;
   logic [31:0] stallCnt, flushCnt;
   exp_t q[$];
   string nq[$];
   int tests = 0, fails = 0;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .rs1ReadEnable(rs1ReadEnable), .rs1ReadAddr(rs1ReadAddr),
      .rs2ReadEnable(rs2ReadEnable), .rs2ReadAddr(rs2ReadAddr),
      .rdWriteEnableE(rdWriteEnableE), .rdWriteAddrE(rdWriteAddrE), .RamReadEnableE(RamReadEnableE),
      .rdWriteEnableM(rdWriteEnableM), .rdWriteAddrM(rdWriteAddrM), .RamReadEnableM(RamReadEnableM),
      .rdWriteEnableW(rdWriteEnableW), .rdWriteAddrW(rdWriteAddrW),
      .redirectE(redirectE), .memReqM(memReqM), .memAckM(memAckM),
      .stallPC(stallPC), .stallF(stallF), .flushF(flushF), .stallD(stallD), .flushD(flushD),
      .stallE(stallE), .stallM(stallM), .flushM(flushM),
      .fwdRs1Sel(fwdRs1Sel), .fwdRs2Sel(fwdRs2Sel), .halted(halted),
      .stallCnt(stallCnt), .flushCnt(flushCnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e, a;
         string n;
         e = q.pop_front();
         n = nq.pop_front();
         a = '{{stallPC, stallF, flushF, stallD, flushD, stallE, stallM, flushM},
               fwdRs1Sel, fwdRs2Sel, halted, stallCnt, flushCnt};
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL %s: got ctl=%b f1=%b f2=%b h=%b sc=%0d fc=%0d, want ctl=%b f1=%b f2=%b h=%b sc=%0d fc=%0d",
                     n, a.ctl, a.f1, a.f2, a.h, a.sc, a.fc, e.ctl, e.f1, e.f2, e.h, e.sc, e.fc);
         end
      end
   end

   task automatic idle();
      {rs1ReadEnable, rs2ReadEnable, rdWriteEnableE, RamReadEnableE, rdWriteEnableM, RamReadEnableM} = '0;
      {rdWriteEnableW, redirectE, memReqM, memAckM} = '0;
      {rs1ReadAddr, rs2ReadAddr, rdWriteAddrE, rdWriteAddrM, rdWriteAddrW} = '0;
   endtask

   task automatic go(input string n, input logic [7:0] ctl, input logic [1:0] f1, input logic [1:0] f2,
                     input logic h, input int sc, input int fc);
      exp_t e;
      e.ctl = ctl; e.f1 = f1; e.f2 = f2; e.h = h; e.sc = 32'(sc); e.fc = 32'(fc);
      q.push_back(e);
      nq.push_back(n);
      @(posedge clk);
      #1 idle();
   endtask

   initial begin
      idle();
      @(posedge clk);
      #1;
      rst = 0; memReqM = 1; redirectE = 1; rs1ReadEnable = 1; rs1ReadAddr = 5; rdWriteEnableE = 1; rdWriteAddrE = 5;
      go("reset_outputs", C_NO, 2'b00, 2'b00, 0, 0, 0);
      rst = 1;
      go("idle", C_NO, 2'b00, 2'b00, 0, 0, 0);
      rs1ReadEnable = 1; rs1ReadAddr = 5; rdWriteEnableE = 1; rdWriteAddrE = 5;
      go("fwd_e_rs1", C_NO, 2'b01, 2'b00, 0, 0, 0);
      rs1ReadEnable = 1; rs1ReadAddr = 0; rdWriteEnableE = 1; rdWriteAddrE = 0;
      go("fwd_x0", C_NO, 2'b00, 2'b00, 0, 0, 0);
      rs1ReadEnable = 1; rs2ReadEnable = 1; rs1ReadAddr = 7; rs2ReadAddr = 7;
      rdWriteEnableE = 1; rdWriteAddrE = 7; rdWriteEnableM = 1; rdWriteAddrM = 7; rdWriteEnableW = 1; rdWriteAddrW = 7;
      go("fwd_prio_e", C_NO, 2'b01, 2'b01, 0, 0, 0);
      rs1ReadEnable = 1; rs2ReadAddr = 7; rs1ReadAddr = 7;
      rdWriteEnableE = 1; rdWriteAddrE = 3; rdWriteEnableM = 1; rdWriteAddrM = 7; rdWriteEnableW = 1; rdWriteAddrW = 7;
      go("fwd_prio_m_rs2off", C_NO, 2'b10, 2'b00, 0, 0, 0);
      rs1ReadEnable = 1; rs2ReadEnable = 1; rs1ReadAddr = 7; rs2ReadAddr = 7; rdWriteEnableW = 1; rdWriteAddrW = 7;
      go("fwd_w", C_NO, 2'b11, 2'b11, 0, 0, 0);
      rs1ReadEnable = 1; rs1ReadAddr = 7; rdWriteAddrW = 7; rdWriteAddrE = 7;
      go("fwd_no_we", C_NO, 2'b00, 2'b00, 0, 0, 0);
      rs2ReadEnable = 1; rs2ReadAddr = 6; rdWriteEnableE = 1; rdWriteAddrE = 6; RamReadEnableE = 1;
      go("lu_load_in_e", C_LU, 2'b00, 2'b00, 0, 0, 0);
      rs2ReadEnable = 1; rs2ReadAddr = 6; rdWriteEnableM = 1; rdWriteAddrM = 6; RamReadEnableM = 1;
      go("lu_load_in_m", C_LU, 2'b00, 2'b00, 0, 1, 0);
      rs2ReadEnable = 1; rs2ReadAddr = 6; rdWriteEnableW = 1; rdWriteAddrW = 6;
      go("lu_load_in_w", C_NO, 2'b00, 2'b11, 0, 2, 0);
      redirectE = 1; rs2ReadEnable = 1; rs2ReadAddr = 6; rdWriteEnableE = 1; rdWriteAddrE = 6; RamReadEnableE = 1;
      go("redirect_over_lu", C_RD, 2'b00, 2'b00, 0, 2, 0);
      go("flushcnt_1", C_NO, 2'b00, 2'b00, 0, 2, 1);
      for (int i = 0; i < 3; i++) begin
         memReqM = 1; redirectE = 1;
         go("mem_wait", C_MW, 2'b00, 2'b00, 0, 2 + i, 1);
      end
      memReqM = 1; memAckM = 1; redirectE = 1;
      go("ack_takes_redirect", C_RD, 2'b00, 2'b00, 0, 5, 1);
      go("after_ack", C_NO, 2'b00, 2'b00, 0, 5, 2);
      for (int i = 0; i < 4; i++) begin
         memReqM = 1;
         go("timeout_wait", C_MW, 2'b00, 2'b00, 0, 5 + i, 2);
      end
      go("halt", C_HT, 2'b00, 2'b00, 1, 9, 2);
      memReqM = 1; memAckM = 1; redirectE = 1; rs1ReadEnable = 1; rs1ReadAddr = 9; rdWriteEnableE = 1; rdWriteAddrE = 9;
      go("halt_sticky", C_HT, 2'b01, 2'b00, 1, 10, 2);
      rst = 0;
      go("halt_reset_cycle", C_NO, 2'b00, 2'b00, 1, 11, 2);
      rst = 1;
      go("halt_cleared", C_NO, 2'b00, 2'b00, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         memReqM = 1;
         go("pre_reset_wait", C_MW, 2'b00, 2'b00, 0, i, 0);
      end
      rst = 0; memReqM = 1;
      go("reset_mid_wait", C_NO, 2'b00, 2'b00, 0, 2, 0);
      rst = 1;
      for (int i = 0; i < 4; i++) begin
         memReqM = 1;
         go("post_reset_wait", C_MW, 2'b00, 2'b00, 0, i, 0);
      end
      go("post_reset_halt", C_HT, 2'b00, 2'b00, 1, 4, 0);
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline hazard and sequencing controller for the 5-stage RV64 core (F, D, E, M, W).
- Generates per-stage stall/flush controls: load-use bubbles, branch/jump redirects, data-memory wait states.
- Generates forwarding selects for the decode-stage operand read feeding id_stage's rs1DataD/rs2DataD.
- Holds a small FSM (memory wait, timeout halt) and performance counters.

Parameters:
MEM_TIMEOUT, 255, max consecutive memory-wait cycles before entering HALT
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-low
rs1ReadEnable  in  1  D-stage rs1 used
rs1ReadAddr  in  5  D-stage rs1 address
rs2ReadEnable  in  1  D-stage rs2 used
rs2ReadAddr  in  5  D-stage rs2 address
rdWriteEnableE  in  1  instr in E writes rd
rdWriteAddrE  in  5  E rd address
RamReadEnableE  in  1  instr in E is a load
rdWriteEnableM  in  1  instr in M writes rd
rdWriteAddrM  in  5  M rd address
RamReadEnableM  in  1  instr in M is a load
rdWriteEnableW  in  1  instr in W writes rd
rdWriteAddrW  in  5  W rd address
redirectE  in  1  taken branch/jump resolved in E
memReqM  in  1  M-stage data-memory request valid
memAckM  in  1  data-memory response/accept this cycle
stallPC  out  1  hold PC
stallF  out  1  hold IF/ID register
flushF  out  1  clear IF/ID register
stallD  out  1  hold D/E register (id_stage stallD)
flushD  out  1  clear D/E register (id_stage flushD)
stallE  out  1  hold E/M register
stallM  out  1  hold M/W register
flushM  out  1  clear M/W register
fwdRs1Sel  out  2  00 regfile, 01 E result, 10 M result, 11 W result
fwdRs2Sel  out  2  same encoding for rs2
halted  out  1  sticky memory-timeout indicator
stallCnt  out  CNT_W  cycles with stallPC asserted
flushCnt  out  CNT_W  redirect flushes taken

Behaviour:
- State register: RUN, MEM_WAIT, HALT. Reset (rst==0 at posedge): state RUN, wait counter 0, stallCnt/flushCnt 0, halted 0.
- While rst low: all stall/flush outputs 0, fwd selects 00.
- Control outputs are combinational from state plus inputs (same-cycle effect). State and counters update on posedge clk.
- Address matching:
  - A match requires the rs enable set, the producer's rdWriteEnable set, and equal addresses.
  - Address 0 never matches.
- Forwarding, independent of stalls: priority E > M > W.
  - An E match where RamReadEnableE=1 selects nothing from E; that case is a load-use hazard.
  - An M match where RamReadEnableM=1 is also load-use (load data is not valid until W).
- Load-use (luHaz): either D operand hits a load in E or M.
  - Action: stallPC=stallF=1, flushD=1 (bubble into E).
  - A load in E yields 2 bubble cycles total (E, then M); a load in M yields 1.
- Redirect (redirectE=1 with no memory wait): flushF=flushD=1, stallPC=0, PC takes target.
  - Overrides luHaz, since the wrong-path D instr is discarded.
  - flushCnt += 1.
- Memory wait (memWait = memReqM & !memAckM):
  - stallPC=stallF=stallD=stallE=stallM=0→1 except M/W: stallPC, stallF, stallD, stallE = 1 and flushM = 1 (bubble into W). stallM = 0.
  - redirectE and luHaz are ignored; they persist because E is held and are acted on in the first non-wait cycle.
- Priority: HALT > memWait > redirect > luHaz > none.
- FSM transitions:
  - RUN→MEM_WAIT on memWait; wait counter := 1.
  - MEM_WAIT stays while memWait and counter increments. Exit to RUN on memAckM, same cycle as the ack, with the counter cleared and no stall from wait in the ack cycle.
  - Counter reaching MEM_TIMEOUT while still waiting → HALT.
  - HALT: stallPC, stallF, stallD, stallE, stallM all 1; flushes 0; halted=1; only reset exits.
- Simultaneous memAckM and a new memReqM in the same cycle: no wait is counted that cycle.
- stallCnt increments every cycle stallPC=1, including HALT.
- Counters wrap modulo 2^CNT_W.

Decomposition:
- Shared defines: FSM state encodings, fwd select encodings (FWD_RF/FWD_E/FWD_M/FWD_W).
- One natural sub-module, fwd_sel: combinational priority forward mux select; instanced twice, once per rs.

Test Plan:
- Forwarding: E writes x5 with an ALU op; D reads rs1=x5 → fwdRs1Sel=01, no stall. Same with rs1=x0 and rd=x0 → 00.
- Load-use: `ld x6` in E; D reads rs2=x6.
  - Cycle 1: stallF=1, flushD=1.
  - Cycle 2: load in M, still stalled.
  - Cycle 3: load in W, fwdRs2Sel=11, no stall. stallCnt=2.
- Redirect: redirectE=1 with a coincident luHaz → flushF=flushD=1, stallPC=0, flushCnt=1.
- Memory wait: memReqM=1 with memAckM held low 3 cycles, then high.
  - Wait cycles: stalls PC..E = 1 and flushM = 1; state MEM_WAIT.
  - Ack cycle: no wait stall, state RUN.
  - A redirectE held throughout is taken only in the ack cycle.
- Timeout (MEM_TIMEOUT=4): memAckM never asserted → HALT after the 4th wait cycle, halted=1 and sticky; rst=0 for one cycle clears it.
- Reset mid-wait: assert rst=0 while in MEM_WAIT → next cycle state RUN, counters 0, all control outputs 0.
